utc_convert_scheduler: RTL

//  Shares one iterative unix64->UTC converter between N requesters: the live clock display,
//  the alarm compare path and the set-time preview. Round-robin arbitration; each grant

---
 rtl/utc_sched_pkg.sv | 32 +++
 rtl/utc_convert_scheduler_rr_pick.sv | 32 +++
 rtl/utc_convert_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/utc_sched_pkg.sv
// Shared encodings and field widths for the unix64->UTC converter scheduler.
package utc_sched_pkg;

  localparam int UNIX_W  = 64;
  localparam int ID_W    = 3;
  localparam int YEAR_W  = 14;
  localparam int MONTH_W = 4;
  localparam int DAY_W   = 5;
  localparam int WDAY_W  = 3;
  localparam int HOUR_W  = 5;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] DELIVER = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_ISSUE   = ISSUE,
    ST_WAIT    = WAIT,
    ST_DELIVER = DELIVER
  } sched_state_t;

  // Increment with explicit wrap at n; never relies on power-of-2 overflow.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v, input int n);
    if (int'(v) >= n - 1) return '0;
    return v + 3'd1;
  endfunction

endpackage

// File: rtl/utc_convert_scheduler_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping to bit 0.
module rr_pick #(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [2:0]       grant_id,
  output logic             any
);

  logic       hi_hit;
  logic [2:0] hi_id;
  logic [2:0] lo_id;

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    hi_hit = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) lo_id = 3'(i);
      if (req[i] && (3'(i) >= ptr)) begin
        hi_hit = 1'b1;
        hi_id  = 3'(i);
      end
    end
  end

  assign any      = |req;
  assign grant_id = hi_hit ? hi_id : lo_id;

endmodule

// File: rtl/utc_convert_scheduler.sv
// Round-robin sharing of one iterative unix64->UTC converter among N_REQ requesters.
// Optional converter watchdog enabled by defining UTC_SCHED_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | pick next requester, latch its time
// ISSUE   | cvt_start pulse is on the bus
// WAIT    | waiting for cvt_done (or watchdog abort)
// DELIVER | ack/res_valid (or ack/err) pulse to the winner
module utc_convert_scheduler
  import utc_sched_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [UNIX_W*N_REQ-1:0] req_time,
  output logic [N_REQ-1:0]        ack,
  output logic                    err,
  output logic                    res_valid,
  output logic [ID_W-1:0]         res_id,
  output logic [YEAR_W-1:0]       res_year,
  output logic [MONTH_W-1:0]      res_month,
  output logic [DAY_W-1:0]        res_day,
  output logic [WDAY_W-1:0]       res_weekday,
  output logic [HOUR_W-1:0]       res_hour,
  output logic [MIN_W-1:0]        res_minute,
  output logic [SEC_W-1:0]        res_second,
  output logic                    cvt_start,
  output logic [UNIX_W-1:0]       cvt_time,
  output logic                    cvt_abort,
  input  logic                    cvt_done,
  input  logic [YEAR_W-1:0]       cvt_year,
  input  logic [MONTH_W-1:0]      cvt_month,
  input  logic [DAY_W-1:0]        cvt_day,
  input  logic [WDAY_W-1:0]       cvt_weekday,
  input  logic [HOUR_W-1:0]       cvt_hour,
  input  logic [MIN_W-1:0]        cvt_minute,
  input  logic [SEC_W-1:0]        cvt_second
);

  sched_state_t      state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   cur_id;
  logic [ID_W-1:0]   pick_id;
  logic              pick_any;
  logic [UNIX_W-1:0] sel_time;
  logic [N_REQ-1:0]  ack_set;
  logic              deliver_ok;
  logic              deliver_err;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req      (req),
    .ptr      (rr_ptr),
    .grant_id (pick_id),
    .any      (pick_any)
  );

  always_comb begin
    sel_time = '0;
    ack_set  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_id == 3'(i)) sel_time = req_time[i*UNIX_W +: UNIX_W];
      ack_set[i] = (cur_id == 3'(i));
    end
  end

`ifdef UTC_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;

  // A done arriving in the abort cycle is stale: the converter is being reset.
  assign deliver_err = (state == ST_WAIT) && cvt_abort;
  assign deliver_ok  = (state == ST_WAIT) && cvt_done && !cvt_abort;

  // Down-counter loaded during ISSUE; terminal count on the last allowed WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      cvt_abort <= 1'b0;
      err       <= 1'b0;
    end else begin
      cvt_abort <= 1'b0;
      err       <= deliver_err;
      if (state == ST_ISSUE) begin
        wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
      end else if ((state == ST_WAIT) && !cvt_done && !cvt_abort) begin
        if (wd_cnt == '0) cvt_abort <= 1'b1;
        else              wd_cnt    <= wd_cnt - 1'b1;
      end
    end
  end
`else
  // Watchdog absent in this build; the limit parameter has no effect.
  localparam bit WD_PRESENT = 1'b0 && (TIMEOUT_CYCLES > 0);

  assign deliver_err = 1'b0;
  assign deliver_ok  = (state == ST_WAIT) && cvt_done;
  assign cvt_abort   = WD_PRESENT;
  assign err         = WD_PRESENT;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      cur_id      <= '0;
      ack         <= '0;
      res_valid   <= 1'b0;
      res_id      <= '0;
      res_year    <= '0;
      res_month   <= 4'd1;
      res_day     <= 5'd1;
      res_weekday <= '0;
      res_hour    <= '0;
      res_minute  <= '0;
      res_second  <= '0;
      cvt_start   <= 1'b0;
      cvt_time    <= '0;
    end else begin
      ack       <= '0;
      res_valid <= 1'b0;
      cvt_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            cur_id    <= pick_id;
            cvt_time  <= sel_time;
            cvt_start <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (deliver_ok || deliver_err) begin
            ack       <= ack_set;
            res_id    <= cur_id;
            res_valid <= deliver_ok;
            state     <= ST_DELIVER;
          end
          if (deliver_ok) begin
            res_year    <= cvt_year;
            res_month   <= cvt_month;
            res_day     <= cvt_day;
            res_weekday <= cvt_weekday;
            res_hour    <= cvt_hour;
            res_minute  <= cvt_minute;
            res_second  <= cvt_second;
          end
        end
        ST_DELIVER: begin
          rr_ptr <= wrap_inc(cur_id, N_REQ);
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
